// File: rtl/i2c_byte_ctrl.sv
// Byte sequencer for the I2C master: expands one host byte operation into
// START / 8 data bits / ACK bit / STOP commands for the bit-level phy.
module i2c_byte_ctrl #(
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             read,
    input  logic             write,
    input  logic             ack_in,
    input  logic [7:0]       din,
    output logic             cmd_ack,
    output logic             ack_out,
    output logic [7:0]       dout,
    output logic             busy,
    output logic             i2c_al,
    output logic [CMD_W-1:0] core_cmd,
    output logic             core_txd,
    input  logic             core_ack,
    input  logic             core_al,
    input  logic             core_rxd
);

    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(4'h0);
    localparam logic [CMD_W-1:0] CMD_START = CMD_W'(4'h1);
    localparam logic [CMD_W-1:0] CMD_STOP  = CMD_W'(4'h2);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(4'h4);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(4'h8);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
    } state_t;

    state_t           state, state_n;
    logic [7:0]       sr, sr_n;
    logic [2:0]       cnt, cnt_n;
    logic [CMD_W-1:0] cmd_n;
    logic             txd_n, cmd_ack_n, ack_out_n;
    logic [7:0]       dout_n;
    logic             go, upd;

    // The acknowledge cycle masks the still-held request so it is not relaunched.
    assign go   = (start | stop | read | write) & ~cmd_ack;
    assign upd  = ena | core_al;
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        cmd_n     = core_cmd;
        txd_n     = core_txd;
        cmd_ack_n = 1'b0;
        ack_out_n = ack_out;
        dout_n    = dout;
        case (state)
            ST_IDLE: if (go) begin
                sr_n  = din;
                cnt_n = 3'd7;
                if (start) begin
                    state_n = ST_START;
                    cmd_n   = CMD_START;
                end else if (read) begin
                    state_n = ST_READ;
                    cmd_n   = CMD_READ;
                end else if (write) begin
                    state_n = ST_WRITE;
                    cmd_n   = CMD_WRITE;
                    txd_n   = din[7];
                end else begin
                    state_n = ST_STOP;
                    cmd_n   = CMD_STOP;
                end
            end
            ST_START: if (core_ack) begin
                if (read) begin
                    state_n = ST_READ;
                    cmd_n   = CMD_READ;
                end else if (write) begin
                    state_n = ST_WRITE;
                    cmd_n   = CMD_WRITE;
                    txd_n   = sr[7];
                end else begin
                    state_n   = ST_IDLE;
                    cmd_n     = CMD_NOP;
                    cmd_ack_n = 1'b1;
                end
            end
            ST_WRITE: if (core_ack) begin
                if (cnt == 3'd0) begin
                    state_n = ST_ACK;
                    cmd_n   = CMD_READ;
                    txd_n   = 1'b1;   // release SDA for the slave ACK
                end else begin
                    sr_n  = {sr[6:0], 1'b0};
                    cnt_n = cnt - 3'd1;
                    txd_n = sr[6];
                end
            end
            ST_READ: if (core_ack) begin
                sr_n = {sr[6:0], core_rxd};
                if (cnt == 3'd0) begin
                    state_n = ST_ACK;
                    cmd_n   = CMD_WRITE;
                    txd_n   = ack_in;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            ST_ACK: if (core_ack) begin
                if (write) ack_out_n = core_rxd;
                if (read)  dout_n    = sr;
                if (stop) begin
                    state_n = ST_STOP;
                    cmd_n   = CMD_STOP;
                end else begin
                    state_n   = ST_IDLE;
                    cmd_n     = CMD_NOP;
                    cmd_ack_n = 1'b1;
                end
            end
            ST_STOP: if (core_ack) begin
                state_n   = ST_IDLE;
                cmd_n     = CMD_NOP;
                cmd_ack_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
                cmd_n   = CMD_NOP;
            end
        endcase
        // Arbitration loss wins over everything, even a frozen core.
        if (core_al) begin
            state_n   = ST_IDLE;
            cmd_n     = CMD_NOP;
            cmd_ack_n = 1'b0;
            ack_out_n = ack_out;
            dout_n    = dout;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    state <= ST_IDLE;
        else if (upd) state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr       <= 8'h00;
            cnt      <= 3'd0;
            core_cmd <= CMD_NOP;
            core_txd <= 1'b0;
            cmd_ack  <= 1'b0;
            ack_out  <= 1'b0;
            dout     <= 8'h00;
            i2c_al   <= 1'b0;
        end else begin
            i2c_al <= core_al;
            if (upd) begin
                sr       <= sr_n;
                cnt      <= cnt_n;
                core_cmd <= cmd_n;
                core_txd <= txd_n;
                cmd_ack  <= cmd_ack_n;
                ack_out  <= ack_out_n;
                dout     <= dout_n;
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: a stub phy acks each command three cycles after
// accepting it; expected (cmd, txd) pairs are queued per operation and popped on accept.
module tb_i2c_byte_ctrl;

    localparam logic [3:0] NOP = 4'h0, STA = 4'h1, STO = 4'h2, WR = 4'h4, RD = 4'h8;

    typedef struct packed {
        logic [3:0] cmd;
        logic       txd;
        logic       chk_txd;
    } exp_t;

    logic       clk = 1'b0, rstn = 1'b0, ena = 1'b1;
    logic       start = 0, stop = 0, read = 0, write = 0, ack_in = 0;
    logic [7:0] din = 8'h00;
    logic       cmd_ack, ack_out, busy, i2c_al, core_txd;
    logic [7:0] dout;
    logic [3:0] core_cmd;
    logic       core_ack = 1'b0, core_al = 1'b0, core_rxd = 1'b1;

    int n_chk = 0, n_pass = 0;
    exp_t exp_q[$];
    logic rx_q[$];
    int   phy_cnt = 0, n_acc = 0;
    logic [3:0] cur_cmd = NOP;
    exp_t e;

    i2c_byte_ctrl #(.CMD_W(4)) dut (
        .clk(clk), .rstn(rstn), .ena(ena), .start(start), .stop(stop),
        .read(read), .write(write), .ack_in(ack_in), .din(din),
        .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout), .busy(busy),
        .i2c_al(i2c_al), .core_cmd(core_cmd), .core_txd(core_txd),
        .core_ack(core_ack), .core_al(core_al), .core_rxd(core_rxd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Stub phy: takes a command when idle, acks it three cycles later.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phy_cnt  <= 0;
            core_ack <= 1'b0;
            core_rxd <= 1'b1;
        end else if (core_al) begin
            phy_cnt  <= 0;
            core_ack <= 1'b0;
        end else if (ena) begin
            core_ack <= 1'b0;
            if (phy_cnt == 0 && !core_ack && core_cmd != NOP) begin
                cur_cmd <= core_cmd;
                phy_cnt <= 3;
                n_acc   <= n_acc + 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 32'(core_cmd), 32'(NOP));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 32'(core_cmd), 32'(e.cmd));
                    if (e.chk_txd) chk("txd", 32'(core_txd), 32'(e.txd));
                end
            end else if (phy_cnt > 0) begin
                phy_cnt <= phy_cnt - 1;
                if (phy_cnt == 1) begin
                    core_ack <= 1'b1;
                    if (cur_cmd == RD) core_rxd <= (rx_q.size() > 0) ? rx_q.pop_front() : 1'b1;
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] c, input logic t, input logic ct);
        exp_t x;
        x.cmd = c; x.txd = t; x.chk_txd = ct;
        exp_q.push_back(x);
    endtask

    task automatic push_wr_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_exp(WR, b[i], 1'b1);
    endtask

    task automatic push_rx_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) rx_q.push_back(b[i]);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Waits for cmd_ack (bounded); counts cycles where busy was low beforehand.
    task automatic wait_done(input string tag, output int busy_low);
        int k;
        k = 0; busy_low = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            k++;
            if (!cmd_ack && !busy) busy_low++;
        end while (!cmd_ack && k < 3000);
        chk({tag, "_done"}, 32'(cmd_ack), 32'd1);
    endtask

    task automatic wait_acc(input int target);
        int k;
        k = 0;
        while (n_acc < target && k < 3000) begin @(negedge clk); k++; end
        chk("acc_wait", 32'(n_acc >= target), 32'd1);
    endtask

    task automatic drop_host;
        start = 0; stop = 0; read = 0; write = 0;
    endtask

    initial begin
        int bl, cnt_ack, bad_cmd, bad_busy, base, chg;
        logic [3:0] cmd0;

        // reset state
        #12;
        chk("rst_cmd", 32'(core_cmd), 32'(NOP));
        chk("rst_txd", 32'(core_txd), 32'd0);
        chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
        chk("rst_ack_out", 32'(ack_out), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_al", 32'(i2c_al), 32'd0);
        @(negedge clk); rstn = 1;
        tick; tick;

        // start + write A5, slave ACK
        push_exp(STA, 1'b0, 1'b0);
        push_wr_byte(8'hA5);
        push_exp(RD, 1'b1, 1'b1);
        rx_q.push_back(1'b0);
        din = 8'hA5; start = 1; write = 1;
        wait_done("t1", bl);
        drop_host;
        chk("t1_ack_out", 32'(ack_out), 32'd0);
        chk("t1_q", 32'(exp_q.size()), 32'd0);
        tick; tick;

        // read + NACK + stop, byte 6C
        for (int i = 0; i < 8; i++) push_exp(RD, 1'b0, 1'b0);
        push_exp(WR, 1'b1, 1'b1);
        push_exp(STO, 1'b0, 1'b0);
        push_rx_byte(8'h6C);
        read = 1; ack_in = 1; stop = 1;
        wait_done("t2", bl);
        chk("t2_q_at_ack", 32'(exp_q.size()), 32'd0);
        drop_host; ack_in = 0;
        chk("t2_dout", 32'(dout), 32'h6C);
        cnt_ack = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (cmd_ack) cnt_ack++; end
        chk("t2_single_ack", 32'(cnt_ack), 32'd0);

        // write only 00, slave NACK; busy from launch to cmd_ack
        push_wr_byte(8'h00);
        push_exp(RD, 1'b1, 1'b1);
        rx_q.push_back(1'b1);
        tick;
        din = 8'h00; write = 1;
        wait_done("t3", bl);
        drop_host;
        chk("t3_busy", 32'(bl), 32'd0);
        chk("t3_ack_out", 32'(ack_out), 32'd1);
        chk("t3_q", 32'(exp_q.size()), 32'd0);
        tick; tick;

        // write held one cycle past cmd_ack: no relaunch
        push_wr_byte(8'h5A);
        push_exp(RD, 1'b1, 1'b1);
        rx_q.push_back(1'b0);
        din = 8'h5A; write = 1;
        wait_done("t6", bl);
        tick;
        drop_host;
        bad_cmd = 0; bad_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (core_cmd != NOP) bad_cmd++;
            if (busy) bad_busy++;
        end
        chk("t6_cmd_nop", 32'(bad_cmd), 32'd0);
        chk("t6_no_busy", 32'(bad_busy), 32'd0);
        chk("t6_ack_out", 32'(ack_out), 32'd0);

        // arbitration loss during the 4th write bit
        push_exp(WR, 1'b1, 1'b1); push_exp(WR, 1'b0, 1'b1);
        push_exp(WR, 1'b1, 1'b1); push_exp(WR, 1'b1, 1'b1);
        base = n_acc;
        tick;
        din = 8'hB6; write = 1;
        wait_acc(base + 4);
        core_al = 1; drop_host;
        tick;
        core_al = 0;
        chk("al_pulse", 32'(i2c_al), 32'd1);
        chk("al_busy", 32'(busy), 32'd0);
        chk("al_cmd", 32'(core_cmd), 32'(NOP));
        chk("al_no_ack", 32'(cmd_ack), 32'd0);
        tick;
        chk("al_pulse_end", 32'(i2c_al), 32'd0);
        chk("al_no_ack2", 32'(cmd_ack), 32'd0);
        chk("al_dout_kept", 32'(dout), 32'h6C);
        chk("al_q", 32'(exp_q.size()), 32'd0);
        tick;

        // ena low for 10 cycles mid-read
        for (int i = 0; i < 8; i++) push_exp(RD, 1'b0, 1'b0);
        push_exp(WR, 1'b0, 1'b1);
        push_rx_byte(8'hC3);
        base = n_acc;
        read = 1; ack_in = 0;
        wait_acc(base + 4);
        ena = 0;
        cmd0 = core_cmd;
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_cmd != cmd0 || !busy || cmd_ack) chg++;
        end
        chk("ena_frozen", 32'(chg), 32'd0);
        ena = 1;
        wait_done("t5", bl);
        drop_host;
        chk("t5_dout", 32'(dout), 32'hC3);
        chk("t5_q", 32'(exp_q.size()), 32'd0);
        tick; tick;

        // reset mid-operation
        push_exp(WR, 1'b0, 1'b1); push_exp(WR, 1'b0, 1'b1);
        base = n_acc;
        din = 8'h3C; write = 1;
        wait_acc(base + 2);
        rstn = 0; drop_host;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cmd", 32'(core_cmd), 32'(NOP));
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_txd", 32'(core_txd), 32'd0);
        tick;
        rstn = 1;
        bad_cmd = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (core_cmd != NOP || busy) bad_cmd++; end
        chk("mrst_idle", 32'(bad_cmd), 32'd0);
        chk("mrst_q", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
